// File: rtl/weights_pkg.sv
// Shared defaults and FSM encodings for the weight streaming bank.
package weights_pkg;

  localparam int DEF_DATA_WIDTH = 5;
  localparam int DEF_LANES      = 3;
  localparam int DEF_ADDR_DEPTH = 12;

  // A zero-length burst reports done after the same two cycles a normal
  // burst takes to present its first beat.
  localparam logic [1:0] ZERO_LEN_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/weights_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are never reset. A read and a write to the same address in one
// cycle return the previous word.
module weights_bank_ram #(
  parameter int WIDTH  = 15,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port and registered read port; nonblocking update gives read-before-write.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/weights_stream_bank.sv
// Weight bank with a burst streaming read port.
// Handshake: a beat moves when out_valid && out_ready at a rising edge;
// out_valid, data_out and out_last come from registers only, never from
// out_ready, and stay stable while out_valid && !out_ready.
// Reads are issued against a credit of two: the number of words held in the
// 2-entry output buffer plus the word in flight from the RAM may never exceed
// two, so no prefetched word is ever dropped and an always-ready consumer
// sees one beat per cycle.
module weights_stream_bank
  import weights_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [ADDR_DEPTH-1:0]       wr_addr,
  input  logic [LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                        start,
  input  logic [ADDR_DEPTH-1:0]       base_addr,
  input  logic [ADDR_DEPTH:0]         burst_len,
  input  logic                        abort,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int W  = LANES * DATA_WIDTH;
  localparam int LW = ADDR_DEPTH + 1;

  state_t state, state_next;

  logic [ADDR_DEPTH-1:0] rd_addr;
  logic [LW-1:0]         issue_rem;
  logic                  rd_en;
  logic [W-1:0]          rd_data;
  logic                  infl_valid;
  logic                  infl_last;
  logic [W-1:0]          buf_data [2];
  logic                  buf_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            occ_after;
  logic [1:0]            fin_wait;
  logic                  pop;
  logic                  last_xfer;
  logic                  flush;

  weights_bank_ram #(
    .WIDTH  (W),
    .ADDR_W (ADDR_DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Handshake terms, flush on abort, and read issue against the buffer credit.
  always_comb begin
    out_valid = (count != 2'd0);
    pop       = out_valid && out_ready;
    last_xfer = pop && buf_last[rd_ptr];
    flush     = (state == STREAM) && abort;
    occ_after = count + {1'b0, infl_valid} - {1'b0, pop};
    rd_en     = (state == STREAM) && !abort && (issue_rem != '0) && (occ_after < 2'd2);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (burst_len == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (abort)          state_next = IDLE;
        else if (last_xfer) state_next = FINISH;
      end
      FINISH: begin
        if (fin_wait == 2'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and the masked output word.
  always_comb begin
    busy     = (state == STREAM);
    done     = (state == FINISH) && (fin_wait == 2'd0);
    data_out = out_valid ? buf_data[rd_ptr] : '0;
    out_last = out_valid && buf_last[rd_ptr];
  end

  // Burst counters, in-flight tracking and output buffer pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr    <= '0;
      issue_rem  <= '0;
      infl_valid <= 1'b0;
      infl_last  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      fin_wait   <= 2'd0;
    end else if (flush) begin
      issue_rem  <= '0;
      infl_valid <= 1'b0;
      infl_last  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (state == IDLE && start) begin
        rd_addr   <= base_addr;
        issue_rem <= burst_len;
        fin_wait  <= (burst_len == '0) ? ZERO_LEN_WAIT : 2'd0;
      end else if (state == FINISH && fin_wait != 2'd0) begin
        fin_wait <= fin_wait - 2'd1;
      end
      if (rd_en) begin
        rd_addr   <= rd_addr + ADDR_DEPTH'(1);
        issue_rem <= issue_rem - LW'(1);
      end
      infl_valid <= rd_en;
      infl_last  <= rd_en && (issue_rem == LW'(1));
      if (infl_valid) wr_ptr <= ~wr_ptr;
      if (pop)        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, infl_valid} - {1'b0, pop};
    end
  end

  // Output buffer storage; occupancy is tracked separately, so no reset here.
  always_ff @(posedge clock) begin
    if (infl_valid) begin
      buf_data[wr_ptr] <= rd_data;
      buf_last[wr_ptr] <= infl_last;
    end
  end

endmodule

// File: tb/tb_weights_stream_bank.sv
// Directed bench for weights_stream_bank with default parameters.
module tb_weights_stream_bank;

  localparam int DW = 5;
  localparam int L  = 3;
  localparam int AD = 12;
  localparam int W  = DW * L;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AD-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic [AD-1:0] base_addr = '0;
  logic [AD:0]   burst_len = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  data_out;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  weights_stream_bank #(
    .DATA_WIDTH (DW),
    .LANES      (L),
    .ADDR_DEPTH (AD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [AD-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns just after the edge that samples start.
  task automatic start_burst(input logic [AD-1:0] b, input logic [AD:0] n);
    start = 1'b1; base_addr = b; burst_len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"},  {17'd0, data_out}, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
  endtask

  // Consumes len beats against exp_q, driving out_ready from a 6-cycle pattern.
  task automatic expect_burst(input string tag, input int len, input logic [5:0] pat, input int budget);
    int n;
    int cyc;
    logic [W-1:0] e;
    n = 0; cyc = 0;
    while (n < len && cyc < budget) begin
      out_ready = pat[cyc % 6];
      if (out_valid) begin
        e = exp_q[0];
        chk({tag, "_data"}, {17'd0, data_out}, {17'd0, e});
        chk({tag, "_last"}, {31'd0, out_last}, (n == len - 1) ? 32'd1 : 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      tick();
      cyc++;
    end
    chk({tag, "_beats"}, n, len);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int vcount;

    // Reset state.
    tick(); tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Basic two-beat burst with exact latency.
    write_word(12'd5, 15'h1234);
    write_word(12'd6, 15'h0ABC);
    out_ready = 1'b1;
    start_burst(12'd5, 13'd2);
    chk("basic_busy_c0", {31'd0, busy}, 32'd1);
    chk("basic_valid_c0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("basic_valid_c1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("basic_valid_c2", {31'd0, out_valid}, 32'd1);
    chk("basic_data_c2", {17'd0, data_out}, 32'h1234);
    chk("basic_last_c2", {31'd0, out_last}, 32'd0);
    tick();
    chk("basic_data_c3", {17'd0, data_out}, 32'h0ABC);
    chk("basic_last_c3", {31'd0, out_last}, 32'd1);
    tick();
    chk("basic_done_c4", {31'd0, done}, 32'd1);
    chk("basic_busy_c4", {31'd0, busy}, 32'd0);
    chk("basic_valid_c4", {31'd0, out_valid}, 32'd0);
    chk("basic_zero_c4", {17'd0, data_out}, 32'd0);
    tick();
    chk("basic_done_c5", {31'd0, done}, 32'd0);

    // Address wrap from 0xFFE.
    write_word(12'hFFE, 15'h4321);
    write_word(12'hFFF, 15'h1111);
    write_word(12'h000, 15'h2222);
    write_word(12'h001, 15'h3333);
    exp_q.push_back(15'h4321); exp_q.push_back(15'h1111);
    exp_q.push_back(15'h2222); exp_q.push_back(15'h3333);
    start_burst(12'hFFE, 13'd4);
    expect_burst("wrap", 4, 6'b111111, 40);

    // Back-pressure with out_ready 1,0,0,1,0,1 repeating.
    for (int i = 0; i < 8; i++) write_word(12'h100 + 12'(i), 15'(15'h0100 + i * 15'h0111));
    for (int i = 0; i < 8; i++) exp_q.push_back(15'(15'h0100 + i * 15'h0111));
    start_burst(12'h100, 13'd8);
    expect_burst("stall", 8, 6'b101001, 80);

    // Zero-length burst: done exactly two cycles after start.
    start_burst(12'h100, 13'd0);
    chk("zero_valid_c0", {31'd0, out_valid}, 32'd0);
    chk("zero_done_c0", {31'd0, done}, 32'd0);
    tick();
    chk("zero_done_c1", {31'd0, done}, 32'd0);
    tick();
    chk("zero_done_c2", {31'd0, done}, 32'd1);
    chk("zero_valid_c2", {31'd0, out_valid}, 32'd0);
    chk("zero_busy_c2", {31'd0, busy}, 32'd0);
    tick();
    chk("zero_done_c3", {31'd0, done}, 32'd0);

    // Start while busy is ignored.
    exp_q.push_back(15'h1234); exp_q.push_back(15'h0ABC);
    start_burst(12'd5, 13'd2);
    start = 1'b1; base_addr = 12'h100; burst_len = 13'd3;
    tick();
    start = 1'b0;
    expect_burst("restart", 2, 6'b111111, 20);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) vcount++;
      tick();
    end
    chk("restart_extra_beats", vcount, 0);

    // Abort after three beats of a ten-beat burst.
    for (int i = 0; i < 10; i++) write_word(12'h200 + 12'(i), 15'(15'h1000 + i * 15'd37));
    out_ready = 1'b1;
    start_burst(12'h200, 13'd10);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("abort_pre_data", {17'd0, data_out}, {17'd0, 15'(15'h1000 + i * 15'd37)});
      tick();
    end
    chk("abort_beat3_data", {17'd0, data_out}, {17'd0, 15'(15'h1000 + 3 * 15'd37)});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle_outputs("abort_next");
    tick();
    chk_idle_outputs("abort_later");
    for (int i = 3; i < 6; i++) exp_q.push_back(15'(15'h1000 + i * 15'd37));
    start_burst(12'h203, 13'd3);
    expect_burst("post_abort", 3, 6'b111111, 20);

    // Asynchronous reset in the middle of a burst.
    start_burst(12'h200, 13'd10);
    tick(); tick(); tick();
    chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk_idle_outputs("rst_async");
    #1 reset_n = 1'b1;
    tick(); tick();
    chk_idle_outputs("rst_after");
    exp_q.push_back(15'h1234); exp_q.push_back(15'h0ABC);
    start_burst(12'd5, 13'd2);
    expect_burst("rst_mem", 2, 6'b111111, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weights_stream_bank.md
WEIGHTS_STREAM_BANK -- requirements
Module: weights_stream_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 5, bit width of one signed weight.
REQ-002 Parameter LANES, default 3, number of weights packed per memory word.
REQ-003 Parameter ADDR_DEPTH, default 12, address bits; memory holds 2**ADDR_DEPTH words.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write strobe for loading weights.
REQ-007 wr_addr  input  ADDR_DEPTH  write address.
REQ-008 wr_data  input  LANES*DATA_WIDTH  write word; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 start  input  1  burst request, sampled only in IDLE.
REQ-010 base_addr  input  ADDR_DEPTH  first burst address, captured with start.
REQ-011 burst_len  input  ADDR_DEPTH+1  number of words in the burst, captured with start.
REQ-012 abort  input  1  cancels the active burst.
REQ-013 out_ready  input  1  consumer can accept a beat.
REQ-014 out_valid  output  1  data_out holds a valid beat.
REQ-015 data_out  output  LANES*DATA_WIDTH  streamed weight word.
REQ-016 out_last  output  1  current beat is the final beat of the burst.
REQ-017 busy  output  1  burst in progress.
REQ-018 done  output  1  one-cycle pulse on burst completion.

Function
REQ-019 Writes SHALL occur at the rising edge with wr_en=1, in any state, to any address.
REQ-020 A same-cycle read and write to one address SHALL return the old word (read-before-write).
REQ-021 The FSM SHALL have states IDLE, STREAM, FINISH.
REQ-022 IDLE: start=1 with burst_len>0 SHALL capture base_addr and burst_len and enter STREAM; busy=1 from the next cycle.
REQ-023 IDLE: start=1 with burst_len=0 SHALL enter FINISH directly; no beats are produced.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 The first out_valid SHALL assert exactly 2 cycles after start is sampled.
REQ-026 Beat i SHALL carry the word at (base_addr+i) mod 2**ADDR_DEPTH; the address wraps from all-ones to 0.
REQ-027 A beat transfers when out_valid=1 and out_ready=1 at a rising edge.
REQ-028 While out_valid=1 and out_ready=0, data_out and out_last SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-029 With out_ready held at 1, one beat SHALL transfer per cycle with no bubbles.
REQ-030 out_valid SHALL NOT depend combinationally on out_ready.
REQ-031 out_last SHALL equal 1 only on beat burst_len-1.
REQ-032 After the last beat transfers, the FSM SHALL enter FINISH; FINISH asserts done=1 for one cycle, busy=0, then returns to IDLE.
REQ-033 abort=1 in STREAM SHALL force IDLE on the next edge: out_valid=0, busy=0, no done, and pending prefetched words are discarded.
REQ-034 abort SHALL be ignored in IDLE and FINISH.
REQ-035 data_out SHALL be all-zeros whenever out_valid=0; the block never drives Z.
REQ-036 A burst_len above 2**ADDR_DEPTH SHALL wrap and re-read words.

Reset
REQ-037 reset_n=0 SHALL immediately force IDLE, out_valid=0, data_out=0, out_last=0, busy=0, done=0, and clear all burst counters.
REQ-038 Memory contents SHALL NOT be reset; weights load only via the write port.
REQ-039 Reset mid-burst SHALL behave as abort with no done pulse; streaming resumes only on a new start.

Structure
REQ-040 Shared package weights_pkg: default DATA_WIDTH, LANES, ADDR_DEPTH, and the FSM state encodings.
REQ-041 One sub-module, weights_bank_ram: simple dual-port synchronous RAM (1 write port, 1 registered read port) with no reset.
REQ-042 The top level holds the FSM, address/beat counters and a 2-entry output skid buffer.

Verification
REQ-043 Write 0x1234 at addr 5 then 0x0ABC at addr 6; start base=5, len=2, out_ready=1 -> beats 0x1234 (last=0) and 0x0ABC (last=1) on cycles 2 and 3 after start; done on cycle 4.
REQ-044 Use base=0xFFE, len=4 with the default depth -> beats read addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
REQ-045 Toggle out_ready 1,0,0,1,0,1 over a len=8 burst -> exactly 8 beats in address order, with data held during every stall.
REQ-046 Use len=0 -> no out_valid and done=1 exactly 2 cycles after start; start during busy -> ignored with no extra beats.
REQ-047 Assert abort after beat 3 of len=10 -> out_valid=0 next cycle, no done; a new burst then streams correctly.
REQ-048 Pulse reset_n low mid-burst -> all outputs are 0 asynchronously, and memory contents are intact on the next burst.
